// File: rtl/datapath_pipe_if.sv
// Operation issue and result bus of the two-stage register-file/ALU datapath.
// The producer of operations uses master; datapath_pipe uses slave.
interface datapath_pipe_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            stall;
  logic [AW-1:0]   read_reg_num1;
  logic [AW-1:0]   read_reg_num2;
  logic [AW-1:0]   write_reg;
  logic [3:0]      alu_control;
  logic            regwrite;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            carry_flag;
  logic            overflow_flag;
  logic [31:0]     retire_count;

  modport master (
    output in_valid, stall, read_reg_num1, read_reg_num2, write_reg,
           alu_control, regwrite,
    input  out_valid, result, zero_flag, carry_flag, overflow_flag,
           retire_count
  );

  modport slave (
    input  in_valid, stall, read_reg_num1, read_reg_num2, write_reg,
           alu_control, regwrite,
    output out_valid, result, zero_flag, carry_flag, overflow_flag,
           retire_count
  );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage RISC-V register file + ALU: RD stage reads/bypasses operands,
// EX stage computes, registers result/flags and writes back.
module datapath_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input logic           clock,
  input logic           reset,
  datapath_pipe_if.slave bus
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001
  } alu_op_e;

  logic [XLEN-1:0] regs [NUM_REGS];

  logic            ex_valid;
  logic            ex_regwrite;
  logic [AW-1:0]   ex_rd;
  alu_op_e         ex_op;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_y;
  logic            alu_c;
  logic            alu_v;
  logic            alu_known;
  logic            alu_z;

  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            fwd_ok;
  logic            wb_en;

  always_comb begin
    sum       = {1'b0, ex_a} + {1'b0, ex_b};
    // carry out of a + ~b + 1 is the inverse of the borrow
    diff      = {1'b0, ex_a} + {1'b0, ~ex_b} + (XLEN+1)'(1);
    shamt     = ex_b[SW-1:0];
    alu_y     = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (ex_op)
      OP_AND:  alu_y = ex_a & ex_b;
      OP_OR:   alu_y = ex_a | ex_b;
      OP_XOR:  alu_y = ex_a ^ ex_b;
      OP_ADD: begin
        alu_y = sum[XLEN-1:0];
        alu_c = sum[XLEN];
        alu_v = (ex_a[XLEN-1] == ex_b[XLEN-1]) && (sum[XLEN-1] != ex_a[XLEN-1]);
      end
      OP_SUB: begin
        alu_y = diff[XLEN-1:0];
        alu_c = diff[XLEN];
        alu_v = (ex_a[XLEN-1] != ex_b[XLEN-1]) && (diff[XLEN-1] != ex_a[XLEN-1]);
      end
      OP_SLL:  alu_y = ex_a << shamt;
      OP_SRL:  alu_y = ex_a >> shamt;
      OP_SRA:  alu_y = $signed(ex_a) >>> shamt;
      OP_SLT:  alu_y = XLEN'($signed(ex_a) < $signed(ex_b));
      OP_SLTU: alu_y = XLEN'(ex_a < ex_b);
      default: alu_known = 1'b0;
    endcase
    alu_z = alu_known && (alu_y == '0);
  end

  always_comb begin
    rd1    = (bus.read_reg_num1 == '0) ? '0 : regs[bus.read_reg_num1];
    rd2    = (bus.read_reg_num2 == '0) ? '0 : regs[bus.read_reg_num2];
    fwd_ok = ex_valid && ex_regwrite && (ex_rd != '0);
    op1    = (fwd_ok && ex_rd == bus.read_reg_num1) ? alu_y : rd1;
    op2    = (fwd_ok && ex_rd == bus.read_reg_num2) ? alu_y : rd2;
    wb_en  = fwd_ok;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= XLEN'(i);
      end
      ex_valid          <= 1'b0;
      ex_regwrite       <= 1'b0;
      ex_rd             <= '0;
      ex_op             <= OP_AND;
      ex_a              <= '0;
      ex_b              <= '0;
      bus.out_valid     <= 1'b0;
      bus.result        <= '0;
      bus.zero_flag     <= 1'b0;
      bus.carry_flag    <= 1'b0;
      bus.overflow_flag <= 1'b0;
      bus.retire_count  <= '0;
    end else if (!bus.stall) begin
      ex_valid <= bus.in_valid;
      if (bus.in_valid) begin
        ex_regwrite <= bus.regwrite;
        ex_rd       <= bus.write_reg;
        ex_op       <= alu_op_e'(bus.alu_control);
        ex_a        <= op1;
        ex_b        <= op2;
      end
      bus.out_valid     <= ex_valid;
      bus.result        <= alu_y;
      bus.zero_flag     <= alu_z;
      bus.carry_flag    <= alu_c;
      bus.overflow_flag <= alu_v;
      if (ex_valid) begin
        bus.retire_count <= bus.retire_count + 32'd1;
      end
      if (wb_en) begin
        regs[ex_rd] <= alu_y;
      end
    end
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: reset preload, ALU ops and flags, bypass,
// x0 handling, stall freeze and reset flush.
module tb_datapath_pipe;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = '0;

  always #5 clock = ~clock;

  datapath_pipe_if #(.XLEN(32), .AW(5)) bus ();

  datapath_pipe #(.XLEN(32), .NUM_REGS(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRL = 4'b0101, SUB = 4'b0110, SLT = 4'b0111;
  localparam logic [3:0] SLTU = 4'b1000, SRA = 4'b1001;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic        we;
    logic [31:0] y;
    logic [2:0]  zcv;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [3:0] op, input logic we);
    bus.in_valid      = v;
    bus.read_reg_num1 = rs1;
    bus.read_reg_num2 = rs2;
    bus.write_reg     = rd;
    bus.alu_control   = op;
    bus.regwrite      = we;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
  endtask

  // issue one op, then leave the pipe empty until its result is on the outputs
  task automatic run_op(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic we);
    drive(1'b1, a, b, d, op, we);
    step();
    idle();
    step();
    exp_ret++;
  endtask

  task automatic test_reset();
    bus.stall = 1'b0;
    reset = 1'b0;
    idle();
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
    checks++; if ({bus.zero_flag, bus.carry_flag, bus.overflow_flag} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {bus.zero_flag, bus.carry_flag, bus.overflow_flag}); end
    checks++; if (bus.retire_count !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d exp 0", bus.retire_count); end
    reset = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_add();
    run_op(ADD, 5'd1, 5'd2, 5'd3, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.result !== 32'd3) begin errors++; $display("FAIL add_result got %h exp 3", bus.result); end
    checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", bus.zero_flag); end
    checks++; if (bus.retire_count !== exp_ret) begin errors++; $display("FAIL add_retire got %0d exp %0d", bus.retire_count, exp_ret); end
    run_op(ADD, 5'd3, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.result !== 32'd3) begin errors++; $display("FAIL add_x3_read got %h exp 3", bus.result); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd1, 5'd5, ADD, 1'b1);
    step();
    drive(1'b1, 5'd5, 5'd5, 5'd6, ADD, 1'b1);
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd2) begin errors++;
      $display("FAIL b2b_first got v=%b %h exp v=1 2", bus.out_valid, bus.result); end
    idle();
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd4) begin errors++;
      $display("FAIL b2b_bypass got v=%b %h exp v=1 4", bus.out_valid, bus.result); end
    exp_ret += 2;
    // x11 comes from the register file, x12 through the bypass
    drive(1'b1, 5'd1, 5'd1, 5'd11, ADD, 1'b1);
    step();
    drive(1'b1, 5'd2, 5'd2, 5'd12, ADD, 1'b1);
    step();
    drive(1'b1, 5'd11, 5'd12, 5'd13, ADD, 1'b1);
    step();
    checks++; if (bus.result !== 32'd4) begin errors++; $display("FAIL dist2_mid got %h exp 4", bus.result); end
    idle();
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd6) begin errors++;
      $display("FAIL dist2_sum got v=%b %h exp v=1 6", bus.out_valid, bus.result); end
    exp_ret += 3;
    checks++; if (bus.retire_count !== exp_ret) begin errors++; $display("FAIL b2b_retire got %0d exp %0d", bus.retire_count, exp_ret); end
  endtask

  task automatic test_alu_ops();
    vec_t tbl [16] = '{
      '{SUB,     5'd0,  5'd1,  5'd7, 1'b1, 32'hFFFF_FFFF, 3'b000},
      '{SRL,     5'd7,  5'd1,  5'd8, 1'b1, 32'h7FFF_FFFF, 3'b000},
      '{ADD,     5'd8,  5'd1,  5'd9, 1'b1, 32'h8000_0000, 3'b001},
      '{ADD,     5'd7,  5'd1,  5'd0, 1'b0, 32'h0000_0000, 3'b110},
      '{SUB,     5'd1,  5'd1,  5'd0, 1'b0, 32'h0000_0000, 3'b110},
      '{SUB,     5'd9,  5'd1,  5'd0, 1'b0, 32'h7FFF_FFFF, 3'b011},
      '{SRA,     5'd9,  5'd4,  5'd0, 1'b0, 32'hF800_0000, 3'b000},
      '{SLL,     5'd1,  5'd31, 5'd0, 1'b0, 32'h8000_0000, 3'b000},
      '{AND_,    5'd7,  5'd5,  5'd0, 1'b0, 32'h0000_0002, 3'b000},
      '{OR_,     5'd3,  5'd4,  5'd0, 1'b0, 32'h0000_0007, 3'b000},
      '{XOR_,    5'd7,  5'd1,  5'd0, 1'b0, 32'hFFFF_FFFE, 3'b000},
      '{SLT,     5'd7,  5'd0,  5'd0, 1'b0, 32'h0000_0001, 3'b000},
      '{SLTU,    5'd0,  5'd31, 5'd0, 1'b0, 32'h0000_0001, 3'b000},
      '{SLT,     5'd31, 5'd0,  5'd0, 1'b0, 32'h0000_0000, 3'b100},
      '{4'b1010, 5'd7,  5'd7,  5'd0, 1'b0, 32'h0000_0000, 3'b000},
      '{4'b1111, 5'd7,  5'd1,  5'd0, 1'b0, 32'h0000_0000, 3'b000}
    };
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].we);
      checks++; if (bus.out_valid !== 1'b1 || bus.result !== tbl[i].y) begin errors++;
        $display("FAIL alu_result[%0d] got v=%b %h exp v=1 %h", i, bus.out_valid, bus.result, tbl[i].y); end
      checks++; if ({bus.zero_flag, bus.carry_flag, bus.overflow_flag} !== tbl[i].zcv) begin errors++;
        $display("FAIL alu_flags[%0d] got %b exp %b", i, {bus.zero_flag, bus.carry_flag, bus.overflow_flag}, tbl[i].zcv); end
    end
  endtask

  task automatic test_x0();
    run_op(ADD, 5'd2, 5'd3, 5'd0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin errors++;
      $display("FAIL x0_write_result got v=%b %h exp v=1 5", bus.out_valid, bus.result); end
    drive(1'b1, 5'd2, 5'd3, 5'd0, ADD, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd14, ADD, 1'b1);
    step();
    idle();
    step();
    exp_ret += 2;
    checks++; if (bus.result !== 32'd0 || bus.zero_flag !== 1'b1) begin errors++;
      $display("FAIL x0_no_bypass got %h z=%b exp 0 z=1", bus.result, bus.zero_flag); end
  endtask

  task automatic test_stall();
    idle();
    step();
    step();
    drive(1'b1, 5'd1, 5'd3, 5'd10, ADD, 1'b1);
    step();
    bus.stall = 1'b1;
    drive(1'b1, 5'd2, 5'd2, 5'd10, SUB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.retire_count !== exp_ret) begin errors++;
        $display("FAIL stall_hold[%0d] got v=%b ret=%0d exp v=0 ret=%0d", i, bus.out_valid, bus.retire_count, exp_ret); end
    end
    bus.stall = 1'b0;
    idle();
    step();
    exp_ret++;
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd4 || bus.retire_count !== exp_ret) begin errors++;
      $display("FAIL stall_release got v=%b %h ret=%0d exp v=1 4 ret=%0d", bus.out_valid, bus.result, bus.retire_count, exp_ret); end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd4 || bus.retire_count !== exp_ret) begin errors++;
        $display("FAIL stall_freeze[%0d] got v=%b %h ret=%0d exp v=1 4 ret=%0d", i, bus.out_valid, bus.result, bus.retire_count, exp_ret); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.retire_count !== exp_ret) begin errors++;
      $display("FAIL stall_once got v=%b ret=%0d exp v=0 ret=%0d", bus.out_valid, bus.retire_count, exp_ret); end
    run_op(ADD, 5'd10, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.result !== 32'd4) begin errors++; $display("FAIL stall_x10 got %h exp 4", bus.result); end
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 5'd1, 5'd2, 5'd4, ADD, 1'b1);
    step();
    reset = 1'b0;
    bus.stall = 1'b1;
    idle();
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.retire_count !== 32'd0) begin errors++;
      $display("FAIL flush_state got v=%b %h ret=%0d exp v=0 0 ret=0", bus.out_valid, bus.result, bus.retire_count); end
    reset = 1'b1;
    bus.stall = 1'b0;
    exp_ret = 0;
    run_op(ADD, 5'd4, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.result !== 32'd4) begin errors++; $display("FAIL flush_x4 got %h exp 4", bus.result); end
    run_op(ADD, 5'd5, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.result !== 32'd5) begin errors++; $display("FAIL flush_x5 got %h exp 5", bus.result); end
    run_op(ADD, 5'd31, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.result !== 32'd31) begin errors++; $display("FAIL flush_x31 got %h exp 31", bus.result); end
    checks++; if (bus.retire_count !== exp_ret) begin errors++; $display("FAIL flush_retire got %0d exp %0d", bus.retire_count, exp_ret); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_x0();
    test_stall();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
